// File: rtl/alu_rot_arbiter_if.sv
// Handshake bundle between two issue-side requesters, the shared rotate-right
// ALU arbiter and the result consumer.
//   req0_* / req1_* : valid/ready request channels carrying operand a and rotate amount b
//   rsp_*           : valid/ready response channel carrying the result r and requester id
// Modports:
//   master : issue/consumer side (drives valids, operands and rsp_ready)
//   slave  : arbiter side (drives readies and the response)
interface alu_rot_arbiter_if #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned AMT_W  = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [AMT_W-1:0]  req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [AMT_W-1:0]  req1_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_r;
    logic              rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_r, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_r, rsp_id
    );
endinterface

// File: rtl/alu_rot_arbiter.sv
// Shares one 7-bit rotate-right datapath between two requesters with round-robin
// arbitration. One operation in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold
// result until consumed).
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous reset, active-high
//   bus      : request/response handshake bundle (slave side)
//   busy     : high whenever the FSM is not idle
//   op_count : completed response handshakes, wraps
module alu_rot_arbiter #(
    parameter int unsigned DATA_W = 7,  // fixed by the rotator
    parameter int unsigned AMT_W  = 3,  // fixed by the rotator
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_rot_arbiter_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [AMT_W-1:0]    op_b_q, op_b_d;
    logic                op_id_q, op_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_r_q, rsp_r_d;
    logic                rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]    op_count_q, op_count_d;

    logic                grant1;
    logic                ready0, ready1;
    logic [2*DATA_W-1:0] rot_wide;
    logic [DATA_W-1:0]   rot_res;

    // Shifting the doubled operand rotates; an amount of 7 is a full turn and yields A.
    assign rot_wide = {op_a_q, op_a_q} >> op_b_q;
    assign rot_res  = rot_wide[DATA_W-1:0];

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant1 = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant1 = ~last_grant_q;
        end
    end

    assign ready0 = (state_q == StIdle) && !rst && bus.req0_valid && !grant1;
    assign ready1 = (state_q == StIdle) && !rst && bus.req1_valid && grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_r_d      = rsp_r_q;
        rsp_id_d     = rsp_id_q;
        op_count_d   = op_count_q;
        unique case (state_q)
            StIdle: begin
                if (ready0 || ready1) begin
                    op_a_d       = grant1 ? bus.req1_a : bus.req0_a;
                    op_b_d       = grant1 ? bus.req1_b : bus.req0_b;
                    op_id_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                rsp_r_d     = rot_res;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_r_q      <= '0;
            rsp_id_q     <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_r_q      <= rsp_r_d;
            rsp_id_q     <= rsp_id_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_id     = rsp_id_q;
    assign busy           = (state_q != StIdle);
    assign op_count       = op_count_q;
endmodule

// File: tb/tb_alu_rot_arbiter.sv
// Directed bench for alu_rot_arbiter: expected responses are queued when an
// operation is issued and compared when the response handshake happens.
module tb_alu_rot_arbiter;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic       id;
        logic [6:0] r;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] cnt_model;
    int               passed = 0;
    int               total = 0;
    exp_t             sb[$];

    alu_rot_arbiter_if #(.DATA_W(7), .AMT_W(3)) bus ();

    alu_rot_arbiter #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chkc(input string tag, input logic [CNT_W-1:0] obs,
                        input logic [CNT_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request alone, expect immediate grant, queue the expected result.
    task automatic issue(input logic id, input logic [6:0] a, input logic [2:0] b,
                         input logic [6:0] r);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        chk1("issue ready", id ? bus.req1_ready : bus.req0_ready, 1'b1);
        sb.push_back({id, r});
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk1("exec busy", busy, 1'b1);
        chk1("exec rsp_valid", bus.rsp_valid, 1'b0);
    endtask

    // Wait (bounded) for a response, compare against the queue, then consume it.
    task automatic collect(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk1({tag, " rsp_valid"}, bus.rsp_valid, 1'b1);
        chk1({tag, " sb nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk7({tag, " rsp_r"}, bus.rsp_r, e.r);
            chk1({tag, " rsp_id"}, bus.rsp_id, e.id);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        cnt_model++;
        chk1({tag, " rsp_valid drop"}, bus.rsp_valid, 1'b0);
        chkc({tag, " op_count"}, op_count, cnt_model);
        chk1({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 7'h53; bus.req0_b = 3'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 7'h01; bus.req1_b = 3'd3;
        bus.rsp_ready = 1'b0;
        cnt_model = '0;

        // Reset held with both valids high
        repeat (3) begin
            tick();
            chk1("rst ready0", bus.req0_ready, 1'b0);
            chk1("rst ready1", bus.req1_ready, 1'b0);
            chk1("rst rsp_valid", bus.rsp_valid, 1'b0);
            chk7("rst rsp_r", bus.rsp_r, 7'h00);
            chk1("rst rsp_id", bus.rsp_id, 1'b0);
            chk1("rst busy", busy, 1'b0);
            chkc("rst op_count", op_count, '0);
        end
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Single request, latency of two edges
        issue(1'b0, 7'h53, 3'd1, 7'h69);
        tick();
        chk1("latency rsp_valid", bus.rsp_valid, 1'b1);
        collect("single");

        // Contention after reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_model = '0;
        bus.req0_valid = 1'b1; bus.req0_a = 7'h53; bus.req0_b = 3'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 7'h01; bus.req1_b = 3'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1("rr ready0", bus.req0_ready, (k % 2) == 0);
            chk1("rr ready1", bus.req1_ready, (k % 2) == 1);
            sb.push_back(((k % 2) == 0) ? {1'b0, 7'h69} : {1'b1, 7'h10});
            tick();
            chk1("rr exec ready0", bus.req0_ready, 1'b0);
            chk1("rr exec ready1", bus.req1_ready, 1'b0);
            collect("rr");
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Rotate amount corner cases
        issue(1'b1, 7'h5A, 3'd0, 7'h5A);
        collect("b0");
        issue(1'b1, 7'h5A, 3'd7, 7'h5A);
        collect("b7");
        issue(1'b0, 7'h40, 3'd6, 7'h01);
        collect("b6");

        // Consumer stall while both requesters wait
        issue(1'b0, 7'h2B, 3'd2, 7'h6A);
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (5) begin
            #1;
            chk1("stall rsp_valid", bus.rsp_valid, 1'b1);
            chk7("stall rsp_r", bus.rsp_r, 7'h6A);
            chk1("stall rsp_id", bus.rsp_id, 1'b0);
            chk1("stall busy", busy, 1'b1);
            chk1("stall ready0", bus.req0_ready, 1'b0);
            chk1("stall ready1", bus.req1_ready, 1'b0);
            tick();
        end
        collect("stall");
        #1;
        chk1("held valid ready1", bus.req1_ready, 1'b1);
        chk1("held valid ready0", bus.req0_ready, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // rsp_ready with no response pending is ignored
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chkc("idle rsp_ready op_count", op_count, cnt_model);
        chk1("idle rsp_ready busy", busy, 1'b0);

        // Reset during EXEC discards the operation
        bus.req0_valid = 1'b1; bus.req0_a = 7'h11; bus.req0_b = 3'd1;
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_model = '0;
        chk1("rst exec busy", busy, 1'b0);
        chkc("rst exec op_count", op_count, cnt_model);
        repeat (3) begin
            chk1("rst exec no rsp", bus.rsp_valid, 1'b0);
            tick();
        end

        // Reset during RESP discards the pending response
        bus.req1_valid = 1'b1; bus.req1_a = 7'h22; bus.req1_b = 3'd2;
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk1("resp pending", bus.rsp_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst resp rsp_valid", bus.rsp_valid, 1'b0);
        chkc("rst resp op_count", op_count, cnt_model);

        // Four completions wrap a 2-bit counter to zero
        for (int k = 0; k < 4; k++) begin
            issue(k[0], 7'h03, 3'd1, 7'h41);
            collect("wrap");
        end
        chkc("wrap op_count zero", op_count, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
